pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Pipeline hazard controller for the 16-bit four-stage core (IF, DOF, EX, WB). It consumes the raw operand-hazard flags produced by the data-hazard detector, along with branch and memory status from EX. It drives the pipeline-register enables, bubble insertion into DOF/EX, IF/DOF flushing and, optionally, the EX-result bypass selects. It also keeps a saturating count of data-stall cycles for performance monitoring.

## Interface
- STALL_CYC, 1: stall cycles per register-file data hazard (1 = write-through register file, 2 = write at end of WB); legal range 1..3.
- clk  in  1  core clock; all state updates on rising edge.
- rst_n  in  1  synchronous reset, active low.
- ha  in  1  raw hazard flag for operand A (DOF source A matches EX destination, destination nonzero, RW set).
- hb  in  1  raw hazard flag for operand B.
- ma  in  1  operand A is taken from PC/constant, not the register file; masks ha.
- mb  in  1  operand B is taken from constant, not the register file; masks hb.
- ex_is_load  in  1  instruction in EX writes its destination from data memory.
- br_taken  in  1  branch/jump in EX resolved taken this cycle.
- mem_wait  in  1  data-memory access in EX not complete.
- pc_en  out  1  PC update enable.
- ifdof_en  out  1  IF/DOF register load enable.
- dofex_en  out  1  DOF/EX register load enable.
- exwb_en  out  1  EX/WB register load enable.
- bubble  out  1  DOF/EX loads NOP (RW=0, MW=0, no branch) instead of DOF contents.
- flush  out  1  IF/DOF loads NOP instead of fetched word.
- fwd_a  out  1  select EX result for operand A (macro-dependent).
- fwd_b  out  1  select EX result for operand B (macro-dependent).
- stall_cnt  out  16  saturating count of data-stall cycles.

## Operation
- hz_a = ha & ~ma; hz_b = hb & ~mb.
- The data-stall condition dstall depends on FORWARD_EN:
  - Without FORWARD_EN: dstall = hz_a | hz_b.
  - With FORWARD_EN: dstall = (hz_a | hz_b) & ex_is_load.
- States: RUN, DSTALL. A 2-bit down-counter cnt is used only in DSTALL.
- Priority per cycle (highest first): reset, mem_wait, br_taken, dstall, normal.
- rst_n low:
  - Outputs: pc_en=ifdof_en=dofex_en=exwb_en=0; bubble=flush=1; fwd_a=fwd_b=0.
  - Next state: RUN, cnt=0, stall_cnt=0.
- mem_wait (any state): all four enables 0, bubble=flush=0. State, cnt and stall_cnt hold.
- RUN, br_taken:
  - Outputs: pc_en=1, ifdof_en=1, flush=1, dofex_en=1, bubble=1, exwb_en=1. Kills the instructions in IF and DOF; dstall is ignored.
  - Next state: RUN.
- RUN, dstall:
  - Outputs: pc_en=0, ifdof_en=0, dofex_en=1, bubble=1, exwb_en=1.
  - stall_cnt increments.
  - If STALL_CYC>1: next state DSTALL with cnt=STALL_CYC-1. Otherwise stay in RUN.
- DSTALL:
  - Outputs: same as the RUN/dstall case; stall_cnt increments.
  - cnt decrements; return to RUN when cnt==1.
  - ha, hb and br_taken are ignored, because EX holds a bubble.
- RUN, none of the above: all enables 1, bubble=flush=0.
- fwd_a/fwd_b:
  - With FORWARD_EN: equal to hz_a/hz_b whenever the current cycle is not a stall, flush or reset; 0 otherwise.
  - Without FORWARD_EN: tied 0.
- stall_cnt saturates at 16'hFFFF and does not wrap.

## Timing
- Enables, bubble, flush and fwd are combinational from state, cnt and inputs: zero-cycle latency. No input-to-output loop exists.
- A data stall holds the consumer in DOF for exactly STALL_CYC cycles, excluding mem_wait cycles, which extend it.
- A taken branch costs 2 cycles (two NOPs enter the pipe).
- stall_cnt updates on the edge ending each counted cycle.
- Reset asserted mid-DSTALL: the next edge gives state RUN and cnt=0. The pipeline is cleared to NOPs at that edge.

## Configuration
- FORWARD_EN defined:
  - Non-load EX→DOF hazards are resolved by bypass; fwd_a/fwd_b are active.
  - Only load-use hazards stall.
- FORWARD_EN undefined: every unmasked hazard stalls and fwd_a/fwd_b are constant 0.

## Structure
- Shared package cpu_pkg holds:
  - State encodings: HZ_RUN=1'b0, HZ_DSTALL=1'b1.
  - STALL_CYC default.
  - The NOP control-word constant used by the pipeline registers.
- One sub-module, sat_counter16 (enable, synchronous active-low clear, saturate at all ones), implements stall_cnt.

## Test plan
- Reset with rst_n=0 for 2 cycles, ha=hb=1 → bubble=flush=1, all enables 0; after release stall_cnt=0, state RUN.
- STALL_CYC=2, no FORWARD_EN, ha=1, ma=0 for one cycle → pc_en=ifdof_en=0 for exactly 2 cycles, bubble=1 both cycles; stall_cnt=2.
- ha=1, ma=1 → no stall, enables all 1, stall_cnt unchanged.
- FORWARD_EN, hb=1, ex_is_load=0 → fwd_b=1, no stall. Same with ex_is_load=1 → fwd_b=0, STALL_CYC-cycle stall.
- br_taken=1 together with ha=1 in RUN → flush=bubble=1, pc_en=1, no stall; stall_cnt unchanged.
- mem_wait=1 for 3 cycles during DSTALL → all enables 0, cnt frozen; DSTALL completes after mem_wait falls; stall_cnt preloaded at 16'hFFFE ends at 16'hFFFF.

Source files
------------

// File: rtl/cpu_pkg.sv
// cpu_pkg: shared state encodings, stall default and pipeline NOP control word.
package cpu_pkg;
  typedef enum logic {HZ_RUN = 1'b0, HZ_DSTALL = 1'b1} hz_state_t;
  localparam int STALL_CYC_DEF = 2;
  typedef struct packed {
    logic rw;
    logic mw;
    logic br;
  } ctrl_t;
  localparam ctrl_t NOP_CTRL = '0;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard/status inputs and pipeline control outputs of the hazard controller.
interface pipe_hazard_ctrl_if;
  logic ha, hb, ma, mb, ex_is_load, br_taken, mem_wait;
  logic pc_en, ifdof_en, dofex_en, exwb_en, bubble, flush, fwd_a, fwd_b;
  logic [15:0] stall_cnt;
  modport master (
    output ha, hb, ma, mb, ex_is_load, br_taken, mem_wait,
    input  pc_en, ifdof_en, dofex_en, exwb_en, bubble, flush, fwd_a, fwd_b, stall_cnt
  );
  modport slave (
    input  ha, hb, ma, mb, ex_is_load, br_taken, mem_wait,
    output pc_en, ifdof_en, dofex_en, exwb_en, bubble, flush, fwd_a, fwd_b, stall_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl_sat_counter16.sv
// sat_counter16: 16-bit counter with enable and sync active-low clear, sticks at all ones.
module sat_counter16 (
  input  logic        clk,
  input  logic        clr_n,
  input  logic        en,
  output logic [15:0] q
);
  always_ff @(posedge clk) begin
    if (!clr_n) q <= '0;
    else if (en && q != 16'hFFFF) q <= q + 16'd1;
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: pipeline stall/flush/bubble control for the 4-stage core.
// Define FORWARD_EN to bypass non-load EX->DOF hazards instead of stalling.
module pipe_hazard_ctrl
  import cpu_pkg::*;
#(
  parameter int STALL_CYC = STALL_CYC_DEF
) (
  input logic clk,
  input logic rst_n,
  pipe_hazard_ctrl_if.slave bus
);
  hz_state_t state, state_n;
  logic [1:0] cnt, cnt_n;
  logic hz_a, hz_b, dstall, act, stall, brk, run;
  always_comb begin
    hz_a = bus.ha & ~bus.ma;
    hz_b = bus.hb & ~bus.mb;
`ifdef FORWARD_EN
    dstall = (hz_a | hz_b) & bus.ex_is_load;
`else
    dstall = hz_a | hz_b;
`endif
    act = rst_n & ~bus.mem_wait;
    // DSTALL ignores br_taken: EX already holds a bubble
    stall = act & (state == HZ_DSTALL | (~bus.br_taken & dstall));
    brk = act & state == HZ_RUN & bus.br_taken;
    run = act & ~stall & ~brk;
    bus.pc_en = brk | run;
    bus.ifdof_en = brk | run;
    bus.dofex_en = brk | stall | run;
    bus.exwb_en = brk | stall | run;
    bus.bubble = ~rst_n | brk | stall;
    bus.flush = ~rst_n | brk;
`ifdef FORWARD_EN
    bus.fwd_a = run & hz_a;
    bus.fwd_b = run & hz_b;
`else
    bus.fwd_a = 1'b0;
    bus.fwd_b = 1'b0;
`endif
    state_n = !stall ? state
            : state == HZ_DSTALL ? (cnt == 2'd1 ? HZ_RUN : HZ_DSTALL)
            : (STALL_CYC > 1 ? HZ_DSTALL : HZ_RUN);
    cnt_n = !stall ? cnt : state == HZ_DSTALL ? cnt - 2'd1 : 2'(STALL_CYC - 1);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= HZ_RUN;
      cnt <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
    end
  end
  sat_counter16 u_cnt (
    .clk  (clk),
    .clr_n(rst_n),
    .en   (stall),
    .q    (bus.stall_cnt)
  );
endmodule
